// File: rtl/mux2x1_response_checker.sv
// Purpose : exhaustive 2:1 mux response checker; drives every {Sel,In0,In1}
//           vector to an external mux, samples Y LAT+1 edges later, counts
//           mismatches and latches the first failing vector.
// Latency : each vector is held LAT+1 cycles; a run takes 2^VW*(LAT+1)
//           cycles from the Start edge to Done.
// Backpr. : none; Start is ignored while Busy, accepted in IDLE or DONE.
// Ports   : Clk/Reset (sync, active-high), Start in; Sel/In0/In1 to the mux;
//           Y back from the mux; Busy, Done, Pass, ErrCount, FirstFail status.
module mux2x1_response_checker #(
   parameter int WIDTH = 1,
   parameter int LAT   = 0
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   output logic                 Sel,
   output logic [WIDTH-1:0]     In0,
   output logic [WIDTH-1:0]     In1,
   input  logic [WIDTH-1:0]     Y,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Pass,
   output logic [15:0]          ErrCount,
   output logic [2*WIDTH:0]     FirstFail
);

   localparam int VW = 2*WIDTH + 1;

   // The CHECK step is not a separate registered state: it is the action
   // taken on the edge that leaves DRIVE (LAT==0) or WAIT (counter at 1),
   // which keeps every vector on the outputs for exactly LAT+1 cycles.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [VW-1:0]    v_q, v_d;
   logic [2:0]       w_q, w_d;
   logic [15:0]      err_q, err_d;
   logic [VW-1:0]    ff_q, ff_d;

   logic [WIDTH-1:0] exp_val;
   logic             mismatch;
   logic             check_now;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         v_q     <= '0;
         w_q     <= '0;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         w_q     <= w_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      v_d       = v_q;
      w_d       = w_q;
      err_d     = err_q;
      ff_d      = ff_q;
      check_now = 1'b0;

      // Expected result comes from the vector register itself, so a broken
      // output path cannot mask its own error.
      exp_val  = v_q[VW-1] ? v_q[WIDTH-1:0] : v_q[2*WIDTH-1:WIDTH];
      // Case inequality so an X/Z on Y is flagged in simulation; hardware
      // sees an ordinary compare.
      mismatch = (Y !== exp_val);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               state_d = S_DRIVE;
               v_d     = '0;
               err_d   = '0;
               ff_d    = '0;
            end
         end
         S_DRIVE: begin
            if (LAT == 0) begin
               check_now = 1'b1;
            end else begin
               w_d     = 3'(LAT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_q == 3'd1) begin
               check_now = 1'b1;
            end else begin
               w_d = w_q - 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (check_now) begin
         if (mismatch) begin
            if (err_q != 16'hFFFF) begin
               err_d = err_q + 16'd1;
            end
            // Counter saturates rather than wraps, so zero means no prior error.
            if (err_q == 16'd0) begin
               ff_d = v_q;
            end
         end
         // All-ones is the last vector; the run ends before V could wrap.
         if (&v_q) begin
            state_d = S_DONE;
         end else begin
            v_d     = v_q + {{(VW-1){1'b0}}, 1'b1};
            state_d = S_DRIVE;
         end
      end
   end

   assign {Sel, In0, In1} = v_q;
   assign Busy      = (state_q == S_DRIVE) || (state_q == S_WAIT);
   assign Done      = (state_q == S_DONE);
   assign Pass      = Done && (err_q == 16'd0);
   assign ErrCount  = err_q;
   assign FirstFail = ff_q;

endmodule

// File: tb/tb_mux2x1_response_checker.sv
// Bench for mux2x1_response_checker: three checker instances, each paired
// with a behavioural mux whose behaviour (correct, stuck, inverted, X,
// registered, random faults) is selected per run.
module tb_mux2x1_response_checker;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic Reset;
   logic start_w [3];

   // instance 0: WIDTH=1, LAT=0
   logic        sel1, a1, b1, y1;
   logic        busy1, done1, pass1;
   logic [15:0] err1;
   logic [2:0]  ff1;
   // instance 1: WIDTH=4, LAT=1, registered correct mux
   logic        sel4a, busy4a, done4a, pass4a;
   logic [3:0]  a4a, b4a, y4a, r4a;
   logic [15:0] err4a;
   logic [8:0]  ff4a;
   // instance 2: WIDTH=4, LAT=0
   logic        sel4b, busy4b, done4b, pass4b;
   logic [3:0]  a4b, b4b, y4b, r4b;
   logic [15:0] err4b;
   logic [8:0]  ff4b;

   int  mode1;
   int  mode4b;
   bit  fault4 [512];

   int nvec = 0;
   int nmis = 0;

   mux2x1_response_checker #(.WIDTH(1), .LAT(0)) u_d1 (
      .Clk(Clk), .Reset(Reset), .Start(start_w[0]),
      .Sel(sel1), .In0(a1), .In1(b1), .Y(y1),
      .Busy(busy1), .Done(done1), .Pass(pass1),
      .ErrCount(err1), .FirstFail(ff1));

   mux2x1_response_checker #(.WIDTH(4), .LAT(1)) u_d4a (
      .Clk(Clk), .Reset(Reset), .Start(start_w[1]),
      .Sel(sel4a), .In0(a4a), .In1(b4a), .Y(y4a),
      .Busy(busy4a), .Done(done4a), .Pass(pass4a),
      .ErrCount(err4a), .FirstFail(ff4a));

   mux2x1_response_checker #(.WIDTH(4), .LAT(0)) u_d4b (
      .Clk(Clk), .Reset(Reset), .Start(start_w[2]),
      .Sel(sel4b), .In0(a4b), .In1(b4b), .Y(y4b),
      .Busy(busy4b), .Done(done4b), .Pass(pass4b),
      .ErrCount(err4b), .FirstFail(ff4b));

   // ---------------- muxes under test ----------------
   always_comb begin
      case (mode1)
         1:       y1 = a1;                          // Sel ignored, stuck on In0
         2:       y1 = b1;                          // Sel ignored, stuck on In1
         3:       y1 = ~(sel1 ? b1 : a1);           // inverted output
         4:       y1 = ({sel1, a1, b1} == 3'b011) ? 1'bx : (sel1 ? b1 : a1);
         default: y1 = sel1 ? b1 : a1;
      endcase
   end

   always_ff @(posedge Clk) r4a <= sel4a ? b4a : a4a;
   assign y4a = r4a;

   always_ff @(posedge Clk) r4b <= sel4b ? b4b : a4b;
   always_comb begin
      if (mode4b == 1) y4b = r4b;
      else if (fault4[{sel4b, a4b, b4b}]) y4b = ~(sel4b ? b4b : a4b);
      else y4b = sel4b ? b4b : a4b;
   end

   // uniform views of the three instances for the shared run task
   logic        busy_w [3];
   logic        done_w [3];
   logic        pass_w [3];
   logic [15:0] err_w  [3];
   logic [8:0]  ff_w   [3];
   logic [8:0]  vec_w  [3];
   assign busy_w[0] = busy1;  assign busy_w[1] = busy4a; assign busy_w[2] = busy4b;
   assign done_w[0] = done1;  assign done_w[1] = done4a; assign done_w[2] = done4b;
   assign pass_w[0] = pass1;  assign pass_w[1] = pass4a; assign pass_w[2] = pass4b;
   assign err_w[0]  = err1;   assign err_w[1]  = err4a;  assign err_w[2]  = err4b;
   assign ff_w[0]   = {6'd0, ff1};
   assign ff_w[1]   = ff4a;
   assign ff_w[2]   = ff4b;
   assign vec_w[0]  = {6'd0, sel1, a1, b1};
   assign vec_w[1]  = {sel4a, a4a, b4a};
   assign vec_w[2]  = {sel4b, a4b, b4b};

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Pulse Start, follow the run to Done (bounded), optionally check that the
   // vector advances once every div cycles and re-pulse Start at cycle poke.
   task automatic run(input int idx, input int div, input int exp_cycles,
                      input int poke, input bit seq, output int cycles);
      start_w[idx] = 1'b1;
      tick();
      start_w[idx] = 1'b0;
      chk("busy_after_start", int'(busy_w[idx]), 1);
      chk("done_cleared",     int'(done_w[idx]), 0);
      chk("err_cleared",      int'(err_w[idx]),  0);
      chk("ff_cleared",       int'(ff_w[idx]),   0);
      cycles = 0;
      while (!done_w[idx] && cycles < exp_cycles + 20) begin
         if (seq) chk("vec_step", int'(vec_w[idx]), cycles / div);
         if (cycles == poke) start_w[idx] = 1'b1;
         tick();
         start_w[idx] = 1'b0;
         cycles++;
      end
      chk("run_cycles",   cycles, exp_cycles);
      chk("done_at_end",  int'(done_w[idx]), 1);
      chk("busy_at_end",  int'(busy_w[idx]), 0);
   endtask

   // Reference mux function on a 9-bit {Sel,In0,In1} vector.
   function automatic int f4(input int v);
      return ((v >> 8) & 1) != 0 ? (v & 15) : ((v >> 4) & 15);
   endfunction

   typedef struct {
      int mode;
      int err;
      int ff;
      int pass;
   } vec1_t;

   initial begin
      vec1_t tab [5];
      int    cyc;
      int    exp_err, exp_ff, prev, guard;

      // 1-bit table: mux behaviour -> expected ErrCount, FirstFail, Pass
      tab[0] = '{0, 0, 0,      1};   // correct mux
      tab[1] = '{1, 2, 3'b101, 0};   // Y=In0: fails 101, 110
      tab[2] = '{2, 2, 3'b001, 0};   // Y=In1: fails 001, 010
      tab[3] = '{3, 8, 0,      0};   // inverted: every vector fails
      tab[4] = '{4, 1, 3'b011, 0};   // X on vector 011

      Reset = 1'b1;
      for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
      mode1  = 0;
      mode4b = 0;
      for (int i = 0; i < 512; i++) fault4[i] = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      tick();

      for (int i = 0; i < 3; i++) begin
         chk("rst_vec",  int'(vec_w[i]),  0);
         chk("rst_busy", int'(busy_w[i]), 0);
         chk("rst_done", int'(done_w[i]), 0);
         chk("rst_pass", int'(pass_w[i]), 0);
         chk("rst_err",  int'(err_w[i]),  0);
         chk("rst_ff",   int'(ff_w[i]),   0);
      end

      // table-driven 1-bit runs (each restart from Done also checks clearing)
      for (int i = 0; i < 5; i++) begin
         mode1 = tab[i].mode;
         run(0, 1, 8, -1, 1'b1, cyc);
         chk("tab_err",  int'(err1),  tab[i].err);
         chk("tab_ff",   int'(ff1),   tab[i].ff);
         chk("tab_pass", int'(pass1), tab[i].pass);
      end

      // Start while Busy is ignored: same length, same sequence
      mode1 = 0;
      run(0, 1, 8, 3, 1'b1, cyc);
      chk("busy_start_pass", int'(pass1), 1);

      // failing run, then restart from Done clears the result
      mode1 = 1;
      run(0, 1, 8, -1, 1'b0, cyc);
      chk("pre_restart_err", int'(err1), 2);
      mode1 = 0;
      run(0, 1, 8, -1, 1'b1, cyc);
      chk("restart_pass", int'(pass1), 1);

      // reset mid-run at V=5 with errors already counted
      mode1 = 3;
      start_w[0] = 1'b1;
      tick();
      start_w[0] = 1'b0;
      guard = 0;
      while (vec_w[0] != 9'd5 && guard < 20) begin
         tick();
         guard++;
      end
      chk("midrun_vec", int'(vec_w[0]), 5);
      chk("midrun_err", int'(err1), 5);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("abort_vec",  int'(vec_w[0]), 0);
      chk("abort_busy", int'(busy1), 0);
      chk("abort_done", int'(done1), 0);
      chk("abort_pass", int'(pass1), 0);
      chk("abort_err",  int'(err1),  0);
      chk("abort_ff",   int'(ff1),   0);
      mode1 = 0;
      run(0, 1, 8, -1, 1'b1, cyc);
      chk("after_abort_pass", int'(pass1), 1);

      // Reset beats Start on the same edge
      Reset = 1'b1;
      start_w[0] = 1'b1;
      tick();
      Reset = 1'b0;
      start_w[0] = 1'b0;
      chk("rst_start_busy", int'(busy1), 0);
      chk("rst_start_vec",  int'(vec_w[0]), 0);
      tick();
      chk("rst_start_idle", int'(busy1), 0);

      // 4-bit registered mux with matching latency
      run(1, 2, 1024, -1, 1'b1, cyc);
      chk("reg_lat1_err",  int'(err4a),  0);
      chk("reg_lat1_pass", int'(pass4a), 1);

      // same registered mux with LAT=0: Y lags one vector behind
      mode4b  = 1;
      exp_err = 0;
      exp_ff  = 0;
      prev    = 0;                     // outputs were 0 before this run
      for (int v = 0; v < 512; v++) begin
         if (f4(prev) != f4(v)) begin
            if (exp_err == 0) exp_ff = v;
            exp_err++;
         end
         prev = v;
      end
      run(2, 1, 512, -1, 1'b0, cyc);
      chk("reg_lat0_err",  int'(err4b), exp_err);
      chk("reg_lat0_ff",   int'(ff4b),  exp_ff);
      chk("reg_lat0_pass", int'(pass4b), 0);

      // random fault sets on a combinational 4-bit mux
      mode4b = 0;
      for (int t = 0; t < 4; t++) begin
         exp_err = 0;
         exp_ff  = 0;
         for (int v = 0; v < 512; v++) begin
            fault4[v] = ($urandom_range(0, 7 + 24*t) == 0);
            if (fault4[v]) begin
               if (exp_err == 0) exp_ff = v;
               exp_err++;
            end
         end
         run(2, 1, 512, -1, 1'b0, cyc);
         chk("rand_err",  int'(err4b),  exp_err);
         chk("rand_ff",   int'(ff4b),   exp_ff);
         chk("rand_pass", int'(pass4b), (exp_err == 0) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/mux2x1_response_checker.md
# mux2x1_response_checker

Self-checking stimulus/response engine for the 2:1 multiplexers in the datapath (1-bit through 8-bit variants). It drives every {Sel, In0, In1} combination into an external mux instance, samples the mux output Y after a fixed latency and compares it against the expected select result. It counts mismatches and reports pass/fail with the first failing vector. It is the receiving, checking end of the exhaustive mux stimulus sequence, synthesizable so it can run in simulation or on the board.

## Interface
Parameters:
- WIDTH, 1, data width of In0/In1/Y; legal range 1..8.
- LAT, 0, edges between a vector appearing on the outputs and the edge that samples Y; 0 suits a purely combinational mux; legal range 0..7.

Derived constant: VW = 2*WIDTH+1 (vector width).

Ports (one clock; reset is synchronous and active-high):
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle request to begin a run.
- Sel  output  1  select driven to the mux under test; registered.
- In0  output  WIDTH  data input 0 to the mux; registered.
- In1  output  WIDTH  data input 1 to the mux; registered.
- Y  input  WIDTH  output returned from the mux under test.
- Busy  output  1  high while a run is in progress.
- Done  output  1  high from run completion until the next Start or Reset.
- Pass  output  1  Done && ErrCount==0.
- ErrCount  output  16  mismatch count, saturating at 16'hFFFF.
- FirstFail  output  VW  {Sel,In0,In1} of the first mismatching vector; 0 if none.

## Operation
- Vector register V[VW-1:0] = {Sel, In0, In1}; outputs are driven directly from V.
- FSM states:
  - IDLE: Busy=0. On Start, go to DRIVE with V=0, ErrCount=0, FirstFail=0, Done=0.
  - DRIVE: V is stable on the outputs. The wait counter W is loaded with LAT. If LAT==0, go directly to CHECK behaviour on this edge; otherwise go to WAIT.
  - WAIT: W decrements each edge; leave for CHECK when W reaches 1.
  - CHECK: sample Y at this edge. Expected value E = Sel ? In1 : In0, taken from V, not re-derived from the outputs.
    - Mismatch (Y !== E; X/Z on Y counts as a mismatch): ErrCount increments unless already saturated. If this is the first error, FirstFail latches V.
    - If V == all-ones, go to DONE. Otherwise V = V+1 and return to DRIVE.
  - DONE: Busy=0, Done=1. V holds its final value (all-ones). On Start, restart as from IDLE; this clears Done, ErrCount and FirstFail on that edge.
- Start is ignored while Busy=1.
- Reset mid-run aborts immediately; no partial result is kept.
- V wrap-around never occurs during a run, because all-ones terminates the run.

## Timing
- Reset values: Sel=0, In0=0, In1=0, Busy=0, Done=0, Pass=0, ErrCount=0, FirstFail=0; state IDLE.
- Start seen at edge t gives Busy=1 and V=0 after edge t.
- Each vector is held for exactly LAT+1 cycles. Y for vector v is sampled at the (LAT+1)-th edge after v appears.
- Total run length is 2^VW*(LAT+1) cycles from the Start edge to Done=1. Done, Pass and the final ErrCount all become valid after the same edge.
- Busy falls on the same edge that Done rises.
- Start and Reset high on the same edge: Reset wins.
- ErrCount at 16'hFFFF stays at 16'hFFFF. This saturation is unreachable for WIDTH≤7 but must still be implemented.

## Test plan
- Correct 1-bit mux, LAT=0: pulse Start. Outputs step through V=0..7, one value per cycle. Done=1 and Pass=1 after exactly 8 cycles; ErrCount=0, FirstFail=0.
- 1-bit mux with Y tied to In0 (Sel ignored), LAT=0: ErrCount=2 (vectors 3'b101 and 3'b110), FirstFail=3'b101, Pass=0.
- 4-bit correct mux behind one register, LAT=1: each vector is held 2 cycles. Done after 2^9*2=1024 cycles with Pass=1. Repeat with LAT=0 against the same registered mux: ErrCount must be nonzero.
- Reset asserted mid-run at V=5, then released: all outputs return to their reset values. A new Start reruns from V=0 and gives a clean result.
- Start pulsed while Busy: no effect, and the total cycle count is unchanged. Start pulsed while Done: the run restarts, and ErrCount/FirstFail from the failing run are cleared on that edge.
- Y driven to X on vector 3'b011: that vector counts as a mismatch, giving ErrCount=1 and FirstFail=3'b011.
